// File: rtl/ioctl_upload_bridge.sv
// ioctl_upload_bridge: serves HPS ioctl upload reads from a variable-latency byte memory port.
// Latency: buffer hit / out-of-range -> ioctl_din at T+1; miss -> ioctl_din one cycle after mem_ready.
// Backpressure: ioctl_wait holds the HPS while a demand fetch (or a stale prefetch drain) is pending.
//
// Ports: clk_sys/reset (async, active-high); ioctl_upload/ioctl_rd/ioctl_addr request side;
// ioctl_din/ioctl_wait response side; mem_addr/mem_rd/mem_data/mem_ready memory side.
// Optional: define UPLOAD_CHECKSUM_EN to add upload_sum, the mod-256 sum of every byte
// presented on ioctl_din in response to a read (cleared by reset and by upload rising edge).
module ioctl_upload_bridge #(
    parameter logic [24:0] BASE_ADDR = 25'd0,
    parameter logic [24:0] MEM_SIZE  = 25'h100000,
    parameter logic [7:0]  FILL      = 8'hFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic [24:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_ready
`ifdef UPLOAD_CHECKSUM_EN
    ,
    output logic [7:0]  upload_sum
`endif
);

    typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH, DISCARD} state_t;

    state_t      state_q, state_d;
    logic        buf_valid_q, buf_valid_d;
    logic [24:0] buf_addr_q, buf_addr_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic [7:0]  din_q, din_d;
    logic        wait_q, wait_d;
    logic        mem_rd_q, mem_rd_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic [24:0] req_addr_q, req_addr_d;   // address of the demand being served
    logic [24:0] pf_addr_q, pf_addr_d;     // address of the speculative fetch in flight
    logic        pending_q, pending_d;     // DISCARD: a demand waits behind the stale fetch
    logic        upload_q;

    logic        req, fill, req_in, up_rise, up_fall, hit;
    logic        deliver, fetch;
    logic [24:0] dlv_addr;
    logic [7:0]  dlv_data;
    logic [25:0] next_addr;

    assign req     = ioctl_rd & ioctl_upload;
    assign fill    = req & (ioctl_addr >= MEM_SIZE);
    assign req_in  = req & (ioctl_addr < MEM_SIZE);
    assign up_rise = ioctl_upload & ~upload_q;
    assign up_fall = ~ioctl_upload & upload_q;
    // A new session never trusts bytes buffered by the previous one.
    assign hit     = buf_valid_q & ~up_rise & (buf_addr_q == ioctl_addr);

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q & ~up_rise;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        din_d       = din_q;
        wait_d      = wait_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        req_addr_d  = req_addr_q;
        pf_addr_d   = pf_addr_q;
        pending_d   = pending_q;
        deliver     = 1'b0;
        fetch       = 1'b0;
        dlv_addr    = ioctl_addr;
        dlv_data    = mem_data;
        next_addr   = 26'd0;

        if (up_fall) begin
            // Session ended: release the HPS, drop any demand, drain an in-flight read silently.
            buf_valid_d = 1'b0;
            wait_d      = 1'b0;
            pending_d   = 1'b0;
            state_d     = (state_q != IDLE && !mem_ready) ? DISCARD : IDLE;
        end else begin
            if (fill) begin
                din_d = FILL;
            end
            unique case (state_q)
                IDLE: begin
                    if (req_in) begin
                        if (hit) begin
                            deliver  = 1'b1;
                            dlv_data = buf_data_q;
                        end else begin
                            fetch = 1'b1;
                        end
                    end
                end
                DEMAND: begin
                    if (mem_ready) begin
                        deliver  = 1'b1;
                        dlv_addr = req_addr_q;
                    end
                end
                PREFETCH: begin
                    if (mem_ready) begin
                        // Latch the prefetched byte first so a same-cycle request can hit it.
                        buf_valid_d = 1'b1;
                        buf_addr_d  = pf_addr_q;
                        buf_data_d  = mem_data;
                        state_d     = IDLE;
                        if (req_in) begin
                            if (ioctl_addr == pf_addr_q) begin
                                deliver = 1'b1;
                            end else begin
                                fetch = 1'b1;
                            end
                        end
                    end else if (req_in) begin
                        wait_d     = 1'b1;
                        req_addr_d = ioctl_addr;
                        if (ioctl_addr == pf_addr_q) begin
                            state_d = DEMAND;
                        end else begin
                            pending_d = 1'b1;
                            state_d   = DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    // Requests can only arrive here after a session abort released ioctl_wait.
                    if (req_in) begin
                        pending_d  = 1'b1;
                        req_addr_d = ioctl_addr;
                        wait_d     = 1'b1;
                    end
                    if (mem_ready) begin
                        if (pending_d) begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = BASE_ADDR + req_addr_d;
                            pending_d  = 1'b0;
                            state_d    = DEMAND;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (fetch) begin
                wait_d     = 1'b1;
                mem_rd_d   = 1'b1;
                mem_addr_d = BASE_ADDR + ioctl_addr;
                req_addr_d = ioctl_addr;
                state_d    = DEMAND;
            end

            if (deliver) begin
                din_d       = dlv_data;
                wait_d      = 1'b0;
                buf_valid_d = 1'b1;
                buf_addr_d  = dlv_addr;
                buf_data_d  = dlv_data;
                // 26-bit compare so the last addressable byte never wraps into a bogus prefetch.
                next_addr   = {1'b0, dlv_addr} + 26'd1;
                if (next_addr < {1'b0, MEM_SIZE}) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = BASE_ADDR + next_addr[24:0];
                    pf_addr_d  = next_addr[24:0];
                    state_d    = PREFETCH;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 25'd0;
            buf_data_q  <= 8'd0;
            din_q       <= 8'd0;
            wait_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= 25'd0;
            req_addr_q  <= 25'd0;
            pf_addr_q   <= 25'd0;
            pending_q   <= 1'b0;
            upload_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            din_q       <= din_d;
            wait_q      <= wait_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            req_addr_q  <= req_addr_d;
            pf_addr_q   <= pf_addr_d;
            pending_q   <= pending_d;
            upload_q    <= ioctl_upload;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;

`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Sum follows ioctl_din: it adds exactly the byte that ioctl_din takes next cycle.
    always_comb begin
        sum_d = up_rise ? 8'd0 : sum_q;
        if (!up_fall && (fill || deliver)) begin
            sum_d = sum_d + din_d;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sum_q <= 8'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign upload_sum = sum_q;
`endif

endmodule
